// File: rtl/digital_tube_pkg.sv
// rtl/digital_tube_pkg.sv - segment patterns, FSM encoding and decode helpers for the tube decoder
package digital_tube_pkg;

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Returns {err, nibble}; unknown patterns decode as nibble 0 with err set.
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      SEG_0: r = 5'h00;
      SEG_1: r = 5'h01;
      SEG_2: r = 5'h02;
      SEG_3: r = 5'h03;
      SEG_4: r = 5'h04;
      SEG_5: r = 5'h05;
      SEG_6: r = 5'h06;
      SEG_7: r = 5'h07;
      SEG_8: r = 5'h08;
      SEG_9: r = 5'h09;
      SEG_A: r = 5'h0A;
      SEG_B: r = 5'h0B;
      SEG_C: r = 5'h0C;
      SEG_D: r = 5'h0D;
      SEG_E: r = 5'h0E;
      SEG_F: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  function automatic logic sel_onehot(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/digital_tube_scan_filter.sv
// rtl/digital_tube_scan_filter.sv - synchronises and normalises the scan bus, strobes once per stable slot
module digital_tube_scan_filter
  import digital_tube_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel_in,
  input  logic [7:0] dig_in,
  output logic       accept_o,
  output logic [3:0] sel_o,
  output logic [7:0] dig_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [3:0]    sel_s1_q, sel_s2_q;
  logic [7:0]    dig_s1_q, dig_s2_q;
  logic [11:0]   cur, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d, accept_q, accept_d;

  assign cur = {(SEL_ACTIVE_LOW ? ~sel_s2_q : sel_s2_q),
                (SEG_ACTIVE_LOW ? ~dig_s2_q : dig_s2_q)};

  always_comb begin
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    accept_d = 1'b0;
    if (cur != prev_q) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX && !flag_q) begin
        accept_d = 1'b1;
        flag_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      dig_s1_q <= '0;
      dig_s2_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      sel_s1_q <= sel_in;
      sel_s2_q <= sel_s1_q;
      dig_s1_q <= dig_in;
      dig_s2_q <= dig_s1_q;
      prev_q   <= cur;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      accept_q <= accept_d;
    end
  end

  // prev_q still holds the accepted sample during the strobe cycle.
  assign accept_o = accept_q;
  assign sel_o    = prev_q[11:8];
  assign dig_o    = prev_q[7:0];

endmodule

// File: rtl/digital_tube_decoder.sv
// rtl/digital_tube_decoder.sv - rebuilds 4-digit frames from a scanned 7-segment bus
// Optional err_cnt output under DIGITAL_TUBE_DECODER_ERRCNT_EN.
module digital_tube_decoder
  import digital_tube_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel_in,
  input  logic [7:0] dig_in,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp_out,
  output logic [3:0] seg_err,
  output logic       frame_valid,
  output logic       timeout
`ifdef DIGITAL_TUBE_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic       acc_raw, accept;
  logic [3:0] acc_sel;
  logic [7:0] acc_dig;
  logic [4:0] dec;

  digital_tube_scan_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEL_ACTIVE_LOW(SEL_ACTIVE_LOW),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .sel_in  (sel_in),
    .dig_in  (dig_in),
    .accept_o(acc_raw),
    .sel_o   (acc_sel),
    .dig_o   (acc_dig)
  );

  assign accept = acc_raw && sel_onehot(acc_sel);
  assign dec    = seg_to_nibble(acc_dig[6:0]);

  state_e          state_q, state_d;
  logic [3:0]      seen_q, seen_d;
  logic [3:0][3:0] shadow_q, shadow_d, out_q, out_d;
  logic [3:0]      sdp_q, sdp_d, serr_q, serr_d, dp_q, dp_d, err_q, err_d;
  logic            fv_q, fv_d, tp_q, tp_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    serr_d   = serr_q;
    out_d    = out_q;
    dp_d     = dp_q;
    err_d    = err_q;
    fv_d     = 1'b0;
    tp_d     = 1'b0;
    tcnt_d   = tcnt_q;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) begin
          shadow_d[i] = dec[3:0];
          sdp_d[i]    = acc_dig[7];
          serr_d[i]   = dec[4];
          seen_d[i]   = 1'b1;
        end
      end
    end
    case (state_q)
      HUNT: begin
        tcnt_d = '0;
        if (accept) state_d = COLLECT;
      end
      COLLECT: begin
        if (seen_q == 4'hF) begin
          out_d   = shadow_q;
          dp_d    = sdp_q;
          err_d   = serr_q;
          fv_d    = 1'b1;
          seen_d  = '0;
          tcnt_d  = '0;
          state_d = HUNT;
        end else if (accept) begin
          tcnt_d = '0;
        end else if (tcnt_q == TMO_MAX) begin
          seen_d  = '0;
          tp_d    = 1'b1;
          tcnt_d  = '0;
          state_d = HUNT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      seen_q   <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      serr_q   <= '0;
      out_q    <= '0;
      dp_q     <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      tp_q     <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      serr_q   <= serr_d;
      out_q    <= out_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      tp_q     <= tp_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign d0          = out_q[0];
  assign d1          = out_q[1];
  assign d2          = out_q[2];
  assign d3          = out_q[3];
  assign dp_out      = dp_q;
  assign seg_err     = err_q;
  assign frame_valid = fv_q;
  assign timeout     = tp_q;

`ifdef DIGITAL_TUBE_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && dec[4] && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_digital_tube_decoder.sv
// tb/tb_digital_tube_decoder.sv - directed self-checking bench for digital_tube_decoder
module tb_digital_tube_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sel_in;
  logic [7:0] dig_in;
  logic [3:0] d0, d1, d2, d3, dp_out, seg_err;
  logic       frame_valid, timeout;
`ifdef DIGITAL_TUBE_DECODER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int tmo_seen = 0;
  int fv_base, tmo_base;

  always #5 clk = ~clk;

  digital_tube_decoder #(
    .STABLE_CYCLES (4),
    .SEL_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_in     (sel_in),
    .dig_in     (dig_in),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .dp_out     (dp_out),
    .seg_err    (seg_err),
    .frame_valid(frame_valid),
    .timeout    (timeout)
`ifdef DIGITAL_TUBE_DECODER_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_seen++;
    if (timeout === 1'b1) tmo_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // seg_ah is {dp, g..a} active-high; the bus is driven inverted (active-low).
  task automatic slot(input int digit, input logic [7:0] seg_ah, input int n);
    logic [3:0] one;
    one    = 4'b0001;
    sel_in = ~(one << digit);
    dig_in = ~seg_ah;
    tick(n);
  endtask

  task automatic blank(input int n);
    sel_in = 4'hF;
    dig_in = 8'hFF;
    tick(n);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] digits,
                             input logic [3:0] dp, input logic [3:0] err);
    check({tag, ".d0"}, 32'(d0), 32'(digits[3:0]));
    check({tag, ".d1"}, 32'(d1), 32'(digits[7:4]));
    check({tag, ".d2"}, 32'(d2), 32'(digits[11:8]));
    check({tag, ".d3"}, 32'(d3), 32'(digits[15:12]));
    check({tag, ".dp"}, 32'(dp_out), 32'(dp));
    check({tag, ".err"}, 32'(seg_err), 32'(err));
  endtask

  initial begin
    rst    = 1'b1;
    sel_in = 4'hF;
    dig_in = 8'hFF;
    tick(3);
    check_frame("reset", 16'h0000, 4'h0, 4'h0);
    check("reset.fv", 32'(frame_valid), 32'd0);
    check("reset.tmo", 32'(timeout), 32'd0);
    rst = 1'b0;
    blank(10);

    // Basic frame: digits 3,7,F,b
    fv_base = fv_seen;
    slot(0, 8'h4F, 20);
    slot(1, 8'h07, 20);
    slot(2, 8'h71, 20);
    slot(3, 8'h7C, 20);
    blank(10);
    check("frame1.count", 32'(fv_seen - fv_base), 32'd1);
    check_frame("frame1", 16'hBF73, 4'h0, 4'h0);

    // Slots one sample short of stable: nothing accepted
    fv_base = fv_seen;
    slot(0, 8'h06, 3);
    slot(1, 8'h5B, 3);
    slot(2, 8'h4F, 3);
    slot(3, 8'h66, 3);
    blank(10);
    check("short.count", 32'(fv_seen - fv_base), 32'd0);
    check_frame("short", 16'hBF73, 4'h0, 4'h0);

    // Exactly stable-length slots: accepted
    slot(0, 8'h06, 4);
    slot(1, 8'h5B, 4);
    slot(2, 8'h4F, 4);
    slot(3, 8'h66, 4);
    blank(10);
    check("exact.count", 32'(fv_seen - fv_base), 32'd1);
    check_frame("exact", 16'h4321, 4'h0, 4'h0);

    // Invalid pattern on slot 2, dp on slot 1
    fv_base = fv_seen;
    slot(0, 8'h7F, 20);
    slot(1, 8'h86, 20);
    slot(2, 8'h00, 20);
    slot(3, 8'h77, 20);
    blank(10);
    check("bad.count", 32'(fv_seen - fv_base), 32'd1);
    check_frame("bad", 16'hA018, 4'h2, 4'h4);
`ifdef DIGITAL_TUBE_DECODER_ERRCNT_EN
    check("bad.err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Partial frame then blanking: timeout after 64 idle cycles
    fv_base  = fv_seen;
    tmo_base = tmo_seen;
    slot(0, 8'h66, 20);
    slot(1, 8'h6D, 20);
    slot(2, 8'h7D, 20);
    blank(40);
    check("tmo.early", 32'(tmo_seen - tmo_base), 32'd0);
    blank(40);
    check("tmo.pulse", 32'(tmo_seen - tmo_base), 32'd1);
    check("tmo.nofv", 32'(fv_seen - fv_base), 32'd0);
    check_frame("tmo.hold", 16'hA018, 4'h2, 4'h4);

    // Digit 1 repeated (5 then 6); digit 3 first exposes stale seen bits
    fv_base = fv_seen;
    slot(3, 8'h4F, 20);
    slot(1, 8'h6D, 20);
    slot(1, 8'h7D, 20);
    check("rep.partial", 32'(fv_seen - fv_base), 32'd0);
    slot(0, 8'h06, 20);
    slot(2, 8'h5B, 20);
    blank(10);
    check("rep.count", 32'(fv_seen - fv_base), 32'd1);
    check_frame("rep", 16'h3261, 4'h0, 4'h0);

    // Reset after two accepts
    tmo_base = tmo_seen;
    slot(0, 8'h6F, 20);
    slot(1, 8'h39, 20);
    rst = 1'b1;
    #2;
    check_frame("rst.async", 16'h0000, 4'h0, 4'h0);
    sel_in = 4'hF;
    dig_in = 8'hFF;
    tick(3);
    check_frame("rst.hold", 16'h0000, 4'h0, 4'h0);
    check("rst.fv", 32'(frame_valid), 32'd0);
    check("rst.tmo", 32'(timeout), 32'd0);
`ifdef DIGITAL_TUBE_DECODER_ERRCNT_EN
    check("rst.err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    blank(10);
    fv_base = fv_seen;
    slot(2, 8'h3F, 20);
    slot(3, 8'h07, 20);
    check("post.partial", 32'(fv_seen - fv_base), 32'd0);
    slot(0, 8'h79, 20);
    slot(1, 8'h5E, 20);
    blank(10);
    check("post.count", 32'(fv_seen - fv_base), 32'd1);
    check("post.notmo", 32'(tmo_seen - tmo_base), 32'd0);
    check_frame("post", 16'h70DE, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
